fp24_result_reader: RTL

FP24_RESULT_READER -- requirements
Module: fp24_result_reader

---
 rtl/fp24_result_reader_pkg.sv | 19 +
 rtl/fp24_result_reader.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fp24_result_reader_pkg.sv
// Shared constants for the Fp24 result readout path: default widths, the
// RAM location of the F result and the readout controller state encoding.
package fp24_result_reader_pkg;

  localparam int WORD_SIZE_DEF     = 16;
  localparam int RAM_ADDR_SIZE_DEF = 8;
  localparam int NUM_WORDS_DEF     = 24;

  // Address of the first word of the F result in core RAM.
  localparam int RAM_F = 'h40;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_CORE = 3'd1;
  localparam logic [2:0] S_ADDR      = 3'd2;
  localparam logic [2:0] S_CAPT      = 3'd3;
  localparam logic [2:0] S_EMIT0     = 3'd4;
  localparam logic [2:0] S_EMIT1     = 3'd5;

endpackage

// File: rtl/fp24_result_reader.sv
// Reads one NUM_WORDS-word Fp24 result out of the core RAM two words at a time
// and streams it word by word over a valid/ready interface.
module fp24_result_reader
  import fp24_result_reader_pkg::*;
#(
  parameter int WORD_SIZE     = WORD_SIZE_DEF,
  parameter int RAM_ADDR_SIZE = RAM_ADDR_SIZE_DEF,
  parameter int NUM_WORDS     = NUM_WORDS_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [RAM_ADDR_SIZE-1:0] base_addr,
  input  logic                     core_busy,
  output logic                     ref_mode,
  output logic [RAM_ADDR_SIZE-1:0] raddr1,
  output logic [RAM_ADDR_SIZE-1:0] raddr2,
  input  logic [WORD_SIZE-1:0]     rdata1,
  input  logic [WORD_SIZE-1:0]     rdata2,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WORD_SIZE-1:0]     m_data,
  output logic                     m_last,
  output logic                     busy,
  output logic                     done
);

  localparam int NUM_PAIRS = NUM_WORDS / 2;
  localparam int K_W       = $clog2(NUM_PAIRS + 1);
  localparam logic [K_W-1:0]           LAST_K   = K_W'(NUM_PAIRS - 1);
  localparam logic [K_W-1:0]           K_ONE    = K_W'(1);
  localparam logic [RAM_ADDR_SIZE-1:0] ADDR_ONE = RAM_ADDR_SIZE'(1);
  localparam logic [RAM_ADDR_SIZE-1:0] ADDR_TWO = RAM_ADDR_SIZE'(2);

  logic [2:0]               state_q;
  logic [2:0]               state_d;
  logic [RAM_ADDR_SIZE-1:0] base_q;
  logic [K_W-1:0]           k_q;
  logic [WORD_SIZE-1:0]     pair_lo_q;
  logic [WORD_SIZE-1:0]     pair_hi_q;
  logic                     done_q;
  logic                     last_pair;

  assign last_pair = (k_q == LAST_K);

  always_comb begin
    // NOTE: defaulting state_d first means every path assigns it, so no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start)      state_d = S_WAIT_CORE;
      S_WAIT_CORE: if (!core_busy) state_d = S_ADDR;
      S_ADDR:                      state_d = S_CAPT;
      S_CAPT:                      state_d = S_EMIT0;
      S_EMIT0:     if (m_ready)    state_d = S_EMIT1;
      S_EMIT1:     if (m_ready)    state_d = last_pair ? S_IDLE : S_ADDR;
      default:                     state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the pair buffer is reset along with the control state so no stale
  // result word can appear on m_data after a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q    <= '0;
      k_q       <= '0;
      raddr1    <= '0;
      raddr2    <= '0;
      pair_lo_q <= '0;
      pair_hi_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q <= base_addr;
            k_q    <= '0;
          end
        end
        S_WAIT_CORE: begin
          if (!core_busy) begin
            raddr1 <= base_q;
            raddr2 <= base_q + ADDR_ONE;
          end
        end
        S_CAPT: begin
          // Core read latency is one cycle: data for the ADDR-cycle address is present now.
          pair_lo_q <= rdata1;
          pair_hi_q <= rdata2;
        end
        S_EMIT1: begin
          if (m_ready) begin
            if (last_pair) begin
              done_q <= 1'b1;
            end else begin
              k_q    <= k_q + K_ONE;
              raddr1 <= raddr1 + ADDR_TWO;
              raddr2 <= raddr2 + ADDR_TWO;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign m_valid  = (state_q == S_EMIT0) || (state_q == S_EMIT1);
  assign m_last   = (state_q == S_EMIT1) && last_pair;
  assign m_data   = (state_q == S_EMIT0) ? pair_lo_q :
                    (state_q == S_EMIT1) ? pair_hi_q : '0;
  // Core stays in result-input mode through every stall until the final handshake.
  assign ref_mode = (state_q == S_ADDR) || (state_q == S_CAPT) || m_valid;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;

endmodule
